nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit adder that feeds one 4-bit slice per clock into the team's
//  4-bit carry-lookahead adder `cla`, registering the slice carry between cycles.

---
 rtl/adder_pkg.sv | 13 +
 rtl/cla.sv | 32 +++
 rtl/nibble_serial_adder.sv | 95 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder and its 4-bit CLA slice.
// Holds the FSM state encoding and the slice width.
package adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice.
// Purely combinational; all carries are computed from generate/propagate terms.
module cla
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit slice per clock through a single CLA,
// with the slice carry registered between cycles.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB  = WIDTH / SLICE_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    state_t             state;
    logic [IDXW-1:0]    idx;
    logic               carry;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_nxt;
    logic [SLICE_W-1:0] cla_sum;
    logic               cla_cout;

    cla u_cla (
        .a    (a_sh[SLICE_W-1:0]),
        .b    (b_sh[SLICE_W-1:0]),
        .cin  (carry),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // New slice enters at the top so slice 0 ends up in the low nibble.
    generate
        if (WIDTH > SLICE_W) begin : g_wide
            assign sum_nxt = {cla_sum, sum[WIDTH-1:SLICE_W]};
        end else begin : g_single
            assign sum_nxt = cla_sum;
        end
    endgenerate

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    sum   <= sum_nxt;
                    carry <= cla_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout  <= cla_cout;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
